// File: rtl/cpu_pkg.sv
// Shared definitions for the phase-1 CPU: opcodes, IR field layout and sequencer states.
package cpu_pkg;

  // IR field layout
  localparam int unsigned OpcodeW   = 5;
  localparam int unsigned RegSelW   = 4;
  localparam int unsigned OpcodeLsb = 27;
  localparam int unsigned RaLsb     = 23;
  localparam int unsigned RbLsb     = 19;
  localparam int unsigned RcLsb     = 15;

  // Opcodes
  localparam logic [OpcodeW-1:0] OpAdd  = 5'd0;
  localparam logic [OpcodeW-1:0] OpSub  = 5'd1;
  localparam logic [OpcodeW-1:0] OpAnd  = 5'd2;
  localparam logic [OpcodeW-1:0] OpOr   = 5'd3;
  localparam logic [OpcodeW-1:0] OpShr  = 5'd4;
  localparam logic [OpcodeW-1:0] OpShra = 5'd5;
  localparam logic [OpcodeW-1:0] OpShl  = 5'd6;
  localparam logic [OpcodeW-1:0] OpRor  = 5'd7;
  localparam logic [OpcodeW-1:0] OpRol  = 5'd8;
  localparam logic [OpcodeW-1:0] OpMul  = 5'd14;
  localparam logic [OpcodeW-1:0] OpDiv  = 5'd15;

  // Control sequencer states
  typedef enum logic [3:0] {
    StIdle,
    StT0,
    StT1,
    StT2,
    StT3,
    StT4,
    StT5,
    StT6,
    StHalt
  } state_e;

  // MUL/DIV produce a 64-bit result and need the extra HI write-back step
  function automatic logic op_is_muldiv(logic [OpcodeW-1:0] op);
    return (op == OpMul) || (op == OpDiv);
  endfunction

  function automatic logic op_is_legal(logic [OpcodeW-1:0] op);
    logic legal;
    case (op)
      OpAdd, OpSub, OpAnd, OpOr, OpShr, OpShra, OpShl, OpRor, OpRol: legal = 1'b1;
      OpMul, OpDiv:                                                 legal = 1'b1;
      default:                                                      legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/control_sequencer_if.sv
// Control bundle between the sequencer and the phase-1 datapath.
// master: the sequencer (drives strobes, observes IR and status).
// slave:  the datapath / environment (drives Run, Stop, MemReady, IR).
interface control_sequencer_if #(
  parameter int unsigned NREGS = 16,
  parameter int unsigned OPW   = 5
);
  // Status and instruction from the datapath side
  logic             Run;
  logic             Stop;
  logic             MemReady;
  logic [31:0]      IR;

  // Bus-out selects
  logic             PCout;
  logic             ZLOout;
  logic             ZHIout;
  logic             MDRout;
  logic             HIout;
  logic             LOout;

  // Register-in enables
  logic             PCin;
  logic             MARin;
  logic             MDRin;
  logic             IRin;
  logic             Yin;
  logic             Zin;
  logic             HIin;
  logic             LOin;

  // Misc controls
  logic             IncrementPC;
  logic             Read;
  logic [OPW-1:0]   ALUControl;
  logic [NREGS-1:0] Rin;
  logic [NREGS-1:0] Rout;
  logic             Halted;

  modport master (
    input  Run, Stop, MemReady, IR,
    output PCout, ZLOout, ZHIout, MDRout, HIout, LOout,
    output PCin, MARin, MDRin, IRin, Yin, Zin, HIin, LOin,
    output IncrementPC, Read, ALUControl, Rin, Rout, Halted
  );

  modport slave (
    output Run, Stop, MemReady, IR,
    input  PCout, ZLOout, ZHIout, MDRout, HIout, LOout,
    input  PCin, MARin, MDRin, IRin, Yin, Zin, HIin, LOin,
    input  IncrementPC, Read, ALUControl, Rin, Rout, Halted
  );

endinterface

// File: rtl/ir_decoder.sv
// Combinational instruction decode: register fields to one-hot selects, op class flags.
module ir_decoder
  import cpu_pkg::*;
#(
  parameter int unsigned NREGS = 16
) (
  input  logic [31:0]        i_ir,
  output logic [OpcodeW-1:0] o_opcode,
  output logic [NREGS-1:0]   o_ra_oh,
  output logic [NREGS-1:0]   o_rb_oh,
  output logic [NREGS-1:0]   o_rc_oh,
  output logic               o_is_muldiv,
  output logic               o_illegal
);

  logic [RegSelW-1:0] w_ra;
  logic [RegSelW-1:0] w_rb;
  logic [RegSelW-1:0] w_rc;
  logic               w_unused_ir;

  assign o_opcode = i_ir[OpcodeLsb +: OpcodeW];
  assign w_ra     = i_ir[RaLsb +: RegSelW];
  assign w_rb     = i_ir[RbLsb +: RegSelW];
  assign w_rc     = i_ir[RcLsb +: RegSelW];

  // Low IR bits carry immediates for later instruction classes
  assign w_unused_ir = ^i_ir[RcLsb-1:0];

  assign o_is_muldiv = op_is_muldiv(o_opcode);
  assign o_illegal   = !op_is_legal(o_opcode);

  // Expand register fields to one-hot; indices beyond NREGS select nothing
  always_comb begin
    o_ra_oh = '0;
    o_rb_oh = '0;
    o_rc_oh = '0;
    for (int unsigned i = 0; i < NREGS; i++) begin
      o_ra_oh[i] = (32'(w_ra) == i);
      o_rb_oh[i] = (32'(w_rb) == i);
      o_rc_oh[i] = (32'(w_rc) == i);
    end
  end

endmodule

// File: rtl/control_sequencer.sv
// Hardwired Moore control unit for the phase-1 datapath: fetch T0-T2, execute T3-T6.
// Outputs decode only the state register and the (already captured) IR.
module control_sequencer
  import cpu_pkg::*;
#(
  parameter int unsigned NREGS = 16,
  parameter int unsigned OPW   = 5
) (
  input logic                 Clock,
  input logic                 Resetn,
  control_sequencer_if.master bus
);

  state_e             r_state;
  state_e             w_state_next;
  state_e             w_retire_state;
  logic               r_stop_pend;
  logic               w_stop_seen;
  logic [OpcodeW-1:0] w_opcode;
  logic [NREGS-1:0]   w_ra_oh;
  logic [NREGS-1:0]   w_rb_oh;
  logic [NREGS-1:0]   w_rc_oh;
  logic               w_is_muldiv;
  logic               w_illegal;

  ir_decoder #(
    .NREGS(NREGS)
  ) u_ir_decoder (
    .i_ir       (bus.IR),
    .o_opcode   (w_opcode),
    .o_ra_oh    (w_ra_oh),
    .o_rb_oh    (w_rb_oh),
    .o_rc_oh    (w_rc_oh),
    .o_is_muldiv(w_is_muldiv),
    .o_illegal  (w_illegal)
  );

  // A Stop arriving in the retire cycle itself must still halt
  assign w_stop_seen    = r_stop_pend | bus.Stop;
  assign w_retire_state = w_stop_seen ? StHalt : (bus.Run ? StT0 : StIdle);

  // Next-state selection
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      StIdle:  w_state_next = bus.Run ? StT0 : StIdle;
      StT0:    w_state_next = StT1;
      StT1:    w_state_next = bus.MemReady ? StT2 : StT1;
      StT2:    w_state_next = StT3;
      StT3:    w_state_next = w_illegal ? StHalt : StT4;
      StT4:    w_state_next = StT5;
      StT5:    w_state_next = w_is_muldiv ? StT6 : w_retire_state;
      StT6:    w_state_next = w_retire_state;
      StHalt:  w_state_next = StHalt;
      default: w_state_next = StIdle;
    endcase
  end

  // State register and pending-stop flag; flag drops on entry to HALT
  always_ff @(posedge Clock) begin
    if (!Resetn) begin
      r_state     <= StIdle;
      r_stop_pend <= 1'b0;
    end else begin
      r_state     <= w_state_next;
      r_stop_pend <= (w_state_next == StHalt) ? 1'b0 : w_stop_seen;
    end
  end

  // Moore output decode
  always_comb begin
    bus.PCout       = 1'b0;
    bus.ZLOout      = 1'b0;
    bus.ZHIout      = 1'b0;
    bus.MDRout      = 1'b0;
    bus.HIout       = 1'b0;  // reserved for mfhi
    bus.LOout       = 1'b0;  // reserved for mflo
    bus.PCin        = 1'b0;
    bus.MARin       = 1'b0;
    bus.MDRin       = 1'b0;
    bus.IRin        = 1'b0;
    bus.Yin         = 1'b0;
    bus.Zin         = 1'b0;
    bus.HIin        = 1'b0;
    bus.LOin        = 1'b0;
    bus.IncrementPC = 1'b0;
    bus.Read        = 1'b0;
    bus.ALUControl  = '0;
    bus.Rin         = '0;
    bus.Rout        = '0;
    bus.Halted      = 1'b0;
    case (r_state)
      StT0: begin
        bus.PCout       = 1'b1;
        bus.MARin       = 1'b1;
        bus.IncrementPC = 1'b1;
        bus.Zin         = 1'b1;
      end
      StT1: begin
        bus.ZLOout = 1'b1;
        bus.PCin   = 1'b1;
        bus.Read   = 1'b1;
        bus.MDRin  = 1'b1;
      end
      StT2: begin
        bus.MDRout = 1'b1;
        bus.IRin   = 1'b1;
      end
      StT3: begin
        // Illegal opcode: quiet cycle, then HALT
        if (!w_illegal) begin
          bus.Rout = w_rb_oh;
          bus.Yin  = 1'b1;
        end
      end
      StT4: begin
        bus.Rout       = w_rc_oh;
        bus.Zin        = 1'b1;
        bus.ALUControl = OPW'(w_opcode);
      end
      StT5: begin
        bus.ZLOout = 1'b1;
        if (w_is_muldiv) begin
          bus.LOin = 1'b1;
        end else begin
          bus.Rin = w_ra_oh;
        end
      end
      StT6: begin
        bus.ZHIout = 1'b1;
        bus.HIin   = 1'b1;
      end
      StHalt: bus.Halted = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: builds an expected per-cycle strobe trace from instruction-level
// rules (fetch, wait states, execute, retire policy), then drives and checks it cycle by cycle.
module tb_control_sequencer;

  localparam int unsigned NREGS = 16;
  localparam int unsigned OPW   = 5;
  localparam int PhIdle = 7;
  localparam int PhHalt = 8;

  typedef struct packed {
    logic pc_out, zlo_out, zhi_out, mdr_out, hi_out, lo_out;
    logic pc_in, mar_in, mdr_in, ir_in, y_in, z_in, hi_in, lo_in;
    logic inc_pc, read;
    logic [4:0]  alu;
    logic [15:0] rin;
    logic [15:0] rout;
    logic halted;
  } outs_t;

  typedef struct {
    outs_t       exp;
    logic        rstn;
    logic        run;
    logic        stop;
    logic        mem;
    logic        ir_set;
    logic [31:0] ir;
    int          ph;
  } rec_t;

  logic        Clock = 1'b0;
  logic        Resetn;
  outs_t       obs;
  rec_t        q[$];
  logic [31:0] cur_ir;
  int          n_cmp = 0;
  int          n_err = 0;
  int          legal_ops[11] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 14, 15};

  control_sequencer_if #(.NREGS(NREGS), .OPW(OPW)) bus ();

  control_sequencer #(
    .NREGS(NREGS),
    .OPW  (OPW)
  ) dut (
    .Clock (Clock),
    .Resetn(Resetn),
    .bus   (bus)
  );

  always #5 Clock = ~Clock;

  assign obs = {bus.PCout, bus.ZLOout, bus.ZHIout, bus.MDRout, bus.HIout, bus.LOout,
                bus.PCin, bus.MARin, bus.MDRin, bus.IRin, bus.Yin, bus.Zin, bus.HIin, bus.LOin,
                bus.IncrementPC, bus.Read, bus.ALUControl, bus.Rin, bus.Rout, bus.Halted};

  function automatic logic coin();
    return 1'($urandom);
  endfunction

  function automatic logic [31:0] enc(int op, int ra, int rb, int rc);
    return (32'(op) << 27) | (32'(ra) << 23) | (32'(rb) << 19) | (32'(rc) << 15)
           | ($urandom & 32'h7fff);
  endfunction

  // Strobes the datapath must see in a given phase of an instruction
  function automatic outs_t phase_outs(int ph, logic [31:0] ir);
    outs_t o;
    int    op, ra, rb, rc;
    bit    legal, md;
    o  = '0;
    op = int'(ir >> 27);
    ra = int'((ir >> 23) & 32'hf);
    rb = int'((ir >> 19) & 32'hf);
    rc = int'((ir >> 15) & 32'hf);
    md = (op == 14) || (op == 15);
    legal = (op <= 8) || md;
    case (ph)
      0: begin o.pc_out = 1; o.mar_in = 1; o.inc_pc = 1; o.z_in = 1; end
      1: begin o.zlo_out = 1; o.pc_in = 1; o.read = 1; o.mdr_in = 1; end
      2: begin o.mdr_out = 1; o.ir_in = 1; end
      3: if (legal) begin o.rout = 16'(1 << rb); o.y_in = 1; end
      4: begin o.rout = 16'(1 << rc); o.z_in = 1; o.alu = 5'(op); end
      5: begin
        o.zlo_out = 1;
        if (md) o.lo_in = 1;
        else    o.rin = 16'(1 << ra);
      end
      6: begin o.zhi_out = 1; o.hi_in = 1; end
      PhHalt: o.halted = 1;
      default: ;
    endcase
    return o;
  endfunction

  function automatic rec_t mk(int ph, logic run, logic mem);
    rec_t r;
    r.exp    = phase_outs(ph, cur_ir);
    r.rstn   = 1'b1;
    r.run    = run;
    r.stop   = 1'b0;
    r.mem    = mem;
    r.ir_set = 1'b0;
    r.ir     = '0;
    r.ph     = ph;
    return r;
  endfunction

  // Append one instruction cycle; returns 1 if this cycle carries a reset (trace cut)
  function automatic bit put(rec_t r, int stop_at, int cut_at, inout int idx);
    r.stop = (idx == stop_at);
    r.rstn = (idx != cut_at);
    q.push_back(r);
    idx++;
    return (idx - 1 == cut_at);
  endfunction

  task automatic go_idle(input int n);
    for (int i = 0; i < n; i++) q.push_back(mk(PhIdle, 1'b0, coin()));
    q.push_back(mk(PhIdle, 1'b1, coin()));
  endtask

  // One instruction from T0; run_end is Run from T3 on; cut_at puts Resetn=0 on that cycle
  task automatic gen_instr(input logic [31:0] ir, input int waits, input int stop_at,
                           input logic run_end, input int cut_at, output bit halts);
    int   op, idx;
    bit   legal, md;
    rec_t r;
    halts = 0;
    idx   = 0;
    op    = int'(ir >> 27);
    md    = (op == 14) || (op == 15);
    legal = (op <= 8) || md;
    if (put(mk(0, 1'b1, coin()), stop_at, cut_at, idx)) return;
    for (int w = 0; w <= waits; w++) begin
      if (put(mk(1, 1'b1, (w == waits)), stop_at, cut_at, idx)) return;
    end
    if (put(mk(2, 1'b1, coin()), stop_at, cut_at, idx)) return;
    cur_ir   = ir;
    r        = mk(3, run_end, coin());
    r.ir_set = 1'b1;
    r.ir     = ir;
    if (put(r, stop_at, cut_at, idx)) return;
    if (!legal) begin
      halts = 1;
      return;
    end
    if (put(mk(4, run_end, coin()), stop_at, cut_at, idx)) return;
    if (put(mk(5, run_end, coin()), stop_at, cut_at, idx)) return;
    if (md) begin
      if (put(mk(6, run_end, coin()), stop_at, cut_at, idx)) return;
    end
    halts = (stop_at >= 0);
  endtask

  // What follows a retired instruction: HALT (held, then reset), IDLE, or back-to-back
  task automatic after(input bit halts, input logic run_end);
    rec_t r;
    if (halts) begin
      for (int i = 0; i < 3; i++) begin
        r      = mk(PhHalt, 1'b1, coin());
        r.stop = coin();
        q.push_back(r);
      end
      r      = mk(PhHalt, 1'b1, coin());
      r.rstn = 1'b0;
      q.push_back(r);
      go_idle(1);
    end else if (!run_end) begin
      go_idle(int'($urandom_range(1, 2)));
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: bench did not complete, observed=timeout required=finish");
    $fatal(1);
  end

  initial begin
    bit h;
    int nbus;
    Resetn       = 1'b0;
    bus.Run      = 1'b0;
    bus.Stop     = 1'b0;
    bus.MemReady = 1'b0;
    cur_ir       = $urandom;
    bus.IR       = cur_ir;

    // Directed scenarios
    go_idle(2);
    gen_instr(enc(2, 1, 2, 3), 0, -1, 1'b1, -1, h);   after(h, 1'b1);  // AND R1,R2,R3
    gen_instr(enc(14, 0, 4, 5), 0, -1, 1'b1, -1, h);  after(h, 1'b1);  // MUL R0,R4,R5
    gen_instr(enc(2, 5, 6, 7), 3, -1, 1'b1, -1, h);   after(h, 1'b1);  // T1 wait x3
    gen_instr(enc(15, 3, 9, 12), 1, -1, 1'b0, -1, h); after(h, 1'b0);  // Run drops
    gen_instr(enc(0, 2, 3, 4), 0, 3, 1'b1, -1, h);    after(h, 1'b1);  // Stop in T3
    gen_instr(enc(1, 7, 8, 9), 0, 1, 1'b1, 4, h);     go_idle(1);      // reset in T4
    gen_instr(enc(6, 10, 11, 13), 0, -1, 1'b1, -1, h); after(h, 1'b1); // stop flag cleared
    gen_instr(enc(3, 4, 4, 4), 3, -1, 1'b1, 2, h);    go_idle(1);      // reset in T1 wait
    gen_instr(enc(20, 1, 2, 3), 0, -1, 1'b1, -1, h);  after(h, 1'b1);  // illegal opcode
    gen_instr(enc(8, 15, 14, 0), 2, 7, 1'b0, -1, h);  after(h, 1'b0);  // Stop on retire

    // Randomized instruction stream
    for (int k = 0; k < 40; k++) begin
      int   op, waits, stop_at;
      logic run_end;
      bit   hh;
      if ($urandom_range(0, 9) == 0) begin
        op = int'($urandom_range(9, 31));
        if (op == 14 || op == 15) op = 20;
      end else begin
        op = legal_ops[$urandom_range(0, 10)];
      end
      waits   = int'($urandom_range(0, 3));
      stop_at = -1;
      if ($urandom_range(0, 7) == 0) stop_at = int'($urandom_range(0, 32'(waits + 3)));
      run_end = ($urandom_range(0, 5) != 0);
      gen_instr(enc(op, int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                    int'($urandom_range(0, 15))), waits, stop_at, run_end, -1, hh);
      after(hh, run_end);
    end

    // Release reset and play the trace
    @(posedge Clock);
    @(posedge Clock);
    #1;
    for (int i = 0; i < q.size(); i++) begin
      Resetn       = q[i].rstn;
      bus.Run      = q[i].run;
      bus.Stop     = q[i].stop;
      bus.MemReady = q[i].mem;
      if (q[i].ir_set) bus.IR = q[i].ir;
      #2;
      n_cmp++;
      assert (obs === q[i].exp)
      else begin
        n_err++;
        $error("FAIL cycle%0d phase%0d: observed=%h required=%h", i, q[i].ph, obs, q[i].exp);
      end
      n_cmp++;
      if (bus.HIout !== 1'b0 || bus.LOout !== 1'b0) begin
        n_err++;
        $error("FAIL cycle%0d: HIout/LOout observed=%b%b required=00", i, bus.HIout, bus.LOout);
      end
      nbus = $countones({bus.PCout, bus.ZLOout, bus.ZHIout, bus.MDRout, bus.HIout, bus.LOout})
             + $countones(bus.Rout);
      n_cmp++;
      if (nbus > 1) begin
        n_err++;
        $error("FAIL cycle%0d: bus drivers observed=%0d required<=1", i, nbus);
      end
      n_cmp++;
      if (!$onehot0(bus.Rin)) begin
        n_err++;
        $error("FAIL cycle%0d: Rin observed=%h required=onehot0", i, bus.Rin);
      end
      n_cmp++;
      if (!$onehot0(bus.Rout)) begin
        n_err++;
        $error("FAIL cycle%0d: Rout observed=%h required=onehot0", i, bus.Rout);
      end
      n_cmp++;
      if (q[i].ph != 4 && bus.ALUControl !== '0) begin
        n_err++;
        $error("FAIL cycle%0d: ALUControl observed=%h required=0", i, bus.ALUControl);
      end
      n_cmp++;
      if (bus.Halted !== (q[i].ph == PhHalt)) begin
        n_err++;
        $error("FAIL cycle%0d: Halted observed=%b required=%b", i, bus.Halted,
               (q[i].ph == PhHalt));
      end
      n_cmp++;
      if ((bus.Read || bus.MDRin) && q[i].ph != 1) begin
        n_err++;
        $error("FAIL cycle%0d phase%0d: Read/MDRin observed=1 required=0", i, q[i].ph);
      end
      n_cmp++;
      if (bus.IRin && q[i].ph != 2) begin
        n_err++;
        $error("FAIL cycle%0d phase%0d: IRin observed=1 required=0", i, q[i].ph);
      end
      n_cmp++;
      if (bus.IncrementPC && q[i].ph != 0) begin
        n_err++;
        $error("FAIL cycle%0d phase%0d: IncrementPC observed=1 required=0", i, q[i].ph);
      end
      n_cmp++;
      if (bus.HIin && q[i].ph != 6) begin
        n_err++;
        $error("FAIL cycle%0d phase%0d: HIin observed=1 required=0", i, q[i].ph);
      end
      @(posedge Clock);
      #1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    if (n_err != 0) begin
      $display("FAIL: mismatches observed=%0d required=0", n_err);
      $fatal(1);
    end
    $finish;
  end

endmodule
